id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection, bubble insertion, branch flush and external-stall hold. It captures decoded operands and control from the ID stage each cycle. Its registered rs/rt/regdst/control outputs drive the EX-stage forwarding unit and ALU. It also emits the stall request that freezes the PC and IF/ID register, and keeps saturating stall/flush performance counters.

## Interface
- DW, 32, datapath width (operands, immediate, PC+4)
- CW, 16, width of the performance counters
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt, id_rd  in  5 each  decoded register fields
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs / rt
- id_rs_data, id_rt_data, id_imm, id_pc4  in  DW each  register-file reads, sign-extended immediate, PC+4
- id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc  in  1 each  decoded control
- id_aluop  in  4  ALU operation
- flush  in  1  branch/jump resolved taken; kill the instruction entering EX
- ext_stall  in  1  downstream memory wait; hold all EX contents
- hazard_stall  out  1  combinational load-use stall to PC/IF-ID write enables
- ex_valid  out  1  EX holds a real instruction
- ex_rs, ex_rt, ex_rd  out  5 each  registered register fields
- ex_wreg  out  5  destination: ex_regdst ? ex_rd : ex_rt
- ex_regdst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc  out  1 each
- ex_aluop  out  4
- ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  DW each
- stall_count, flush_count  out  CW each  saturating event counters

## Operation
- Load-use detect: hazard_stall = ex_valid & ex_memread & (ex_rt != 0) & id_valid & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)). Loads always write rt.
- Per-edge update priority: rst > flush > ext_stall > hazard_stall > load.
  - rst or flush: insert bubble.
  - ext_stall: all ex_* registers hold. hazard_stall may still assert and is not counted.
  - hazard_stall: insert bubble. The ID instruction stays in IF/ID, held by the core, and re-presents next cycle.
  - load: ex_valid <= id_valid; every other field is copied from its id_* counterpart.
- Bubble: ex_valid=0, all control bits 0, ex_aluop=0, ex_rs/ex_rt/ex_rd=0, all data fields 0. The zeroed registers guarantee no forwarding match and no write.
- A bubble generated from a load-use stall clears ex_memread. This bounds the stall to exactly one cycle per dependent instruction.
- stall_count increments by 1 on each edge where hazard_stall=1 and rst=flush=ext_stall=0.
- flush_count increments by 1 on each edge where flush=1 and rst=0, regardless of ext_stall.
- Both counters saturate at 2^CW-1, with no wrap.
- ex_wreg is combinational from registered state. For a bubble it is 0.

## Timing
- Reset: one rst edge zeroes every ex_* output, ex_wreg, stall_count and flush_count. hazard_stall is 0 while rst-driven state is bubble.
- Latency: id_* sampled at edge N appear on ex_* after edge N, one cycle.
- hazard_stall is valid in the same cycle as the offending ID instruction. It is asserted for exactly one cycle per load-use pair unless ext_stall extends it.
- Simultaneous events:
  - flush with hazard_stall: flush wins, only flush_count increments.
  - flush with ext_stall: flush wins, and EX becomes a bubble.
  - rst with anything: reset wins.
- Reset mid-stall: the next cycle has ex_valid=0, hazard_stall=0, and counters at 0.
- Register 0 is never a hazard source. A load to $0 never stalls.

## Test plan
- rst=1 for 1 cycle with all inputs at random values -> all ex_* = 0, counters = 0, hazard_stall = 0.
- lw $8 (id_memread=1, id_rt=8, id_valid=1), then add $9,$8,$3 (id_rs=8, uses_rs=1) -> hazard_stall=1 for one cycle, then EX shows a bubble (ex_valid=0, ex_rs=0), the add enters EX on the following edge, and stall_count=1.
- lw $0 followed by a reader of $0; separately, lw $8 followed by an instruction with uses_rt=0 and id_rt=8 -> hazard_stall stays 0 in both cases.
- flush=1 and hazard_stall=1 on the same edge -> EX bubble, flush_count=1, stall_count=0.
- ext_stall=1 for 3 cycles while a valid instruction is in EX and id_* inputs change -> ex_* stay unchanged for those 3 cycles, and load resumes on the first edge with ext_stall=0.
- CW=2, drive 5 load-use stalls -> stall_count reads 1, 2, 3, 3, 3 (saturates, no wrap).

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Detects load-use hazards, inserts bubbles on flush or stall, holds on ext_stall, and keeps saturating event counters.
module id_ex_pipe #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc4,
  input  logic          id_regdst,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          id_alusrc,
  input  logic [3:0]    id_aluop,
  input  logic          flush,
  input  logic          ext_stall,
  output logic          hazard_stall,
  output logic          ex_valid,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [4:0]    ex_wreg,
  output logic          ex_regdst,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_alusrc,
  output logic [3:0]    ex_aluop,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          regdst;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic          alusrc;
    logic [3:0]    aluop;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
  } ex_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  ex_t           ex_q, ex_d, id_s;
  logic [CW-1:0] stall_count_q, stall_count_d;
  logic [CW-1:0] flush_count_q, flush_count_d;
  logic          hazard_stall_s;

  assign id_s = '{valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd,
                  regdst: id_regdst, regwrite: id_regwrite, memread: id_memread,
                  memwrite: id_memwrite, memtoreg: id_memtoreg, alusrc: id_alusrc,
                  aluop: id_aluop, rs_data: id_rs_data, rt_data: id_rt_data,
                  imm: id_imm, pc4: id_pc4};

  // Load-use detection: a load in EX whose rt feeds the instruction in ID; $0 never stalls.
  always_comb begin
    hazard_stall_s = ex_q.valid & ex_q.memread & (ex_q.rt != 5'd0) & id_valid &
                     ((id_uses_rs & (id_rs == ex_q.rt)) | (id_uses_rt & (id_rt == ex_q.rt)));
  end

  // Next EX contents and counter values, priority flush > ext_stall > hazard > load.
  always_comb begin
    ex_d          = ex_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (flush) begin
      ex_d = '0;
    end else if (ext_stall) begin
      ex_d = ex_q;
    end else if (hazard_stall_s) begin
      ex_d = '0;
    end else begin
      ex_d = id_s;
    end
    if (flush && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end else begin
      flush_count_d = flush_count_q;
    end
    if (hazard_stall_s && !flush && !ext_stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State registers with synchronous reset to a bubble and cleared counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= '0;
      stall_count_q <= {CW{1'b0}};
      flush_count_q <= {CW{1'b0}};
    end else begin
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hazard_stall = hazard_stall_s;
  assign ex_valid     = ex_q.valid;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_rd        = ex_q.rd;
  assign ex_wreg      = ex_q.regdst ? ex_q.rd : ex_q.rt;
  assign ex_regdst    = ex_q.regdst;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_memread   = ex_q.memread;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_memtoreg  = ex_q.memtoreg;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_aluop     = ex_q.aluop;
  assign ex_rs_data   = ex_q.rs_data;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_imm       = ex_q.imm;
  assign ex_pc4       = ex_q.pc4;
  assign stall_count  = stall_count_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Randomized and directed bench for id_ex_pipe, checked every cycle against an in-bench reference model.
module tb_id_ex_pipe;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam logic [CW-1:0] MAXC = {CW{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_valid, id_uses_rs, id_uses_rt;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic          id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
  logic [3:0]    id_aluop;
  logic          flush, ext_stall;
  logic          hazard_stall, ex_valid;
  logic [4:0]    ex_rs, ex_rt, ex_rd, ex_wreg;
  logic          ex_regdst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic [3:0]    ex_aluop;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [CW-1:0] stall_count, flush_count;

  id_ex_pipe #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4), .id_regdst(id_regdst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_aluop(id_aluop), .flush(flush),
    .ext_stall(ext_stall), .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_regdst(ex_regdst),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Expected EX contents as a plain record of the stage's visible fields.
  typedef struct packed {
    logic valid; logic [4:0] rs, rt, rd;
    logic regdst, regwrite, memread, memwrite, memtoreg, alusrc;
    logic [3:0] aluop; logic [DW-1:0] rs_data, rt_data, imm, pc4;
  } rec_t;

  rec_t          m_ex;
  int            m_sc, m_fc;
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic rec_t id_view();
    return '{id_valid, id_rs, id_rt, id_rd, id_regdst, id_regwrite, id_memread, id_memwrite,
             id_memtoreg, id_alusrc, id_aluop, id_rs_data, id_rt_data, id_imm, id_pc4};
  endfunction

  function automatic rec_t dut_view();
    return '{ex_valid, ex_rs, ex_rt, ex_rd, ex_regdst, ex_regwrite, ex_memread, ex_memwrite,
             ex_memtoreg, ex_alusrc, ex_aluop, ex_rs_data, ex_rt_data, ex_imm, ex_pc4};
  endfunction

  // Does the instruction in ID need a value the load in EX has not produced yet?
  function automatic bit model_hazard();
    bit rs_dep, rt_dep;
    rs_dep = id_uses_rs && (id_rs == m_ex.rt);
    rt_dep = id_uses_rt && (id_rt == m_ex.rt);
    return m_ex.valid && m_ex.memread && (m_ex.rt != 5'd0) && id_valid && (rs_dep || rt_dep);
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_nop();
    rst = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0; id_pc4 = 32'd0;
    id_regdst = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
    id_memtoreg = 1'b0; id_alusrc = 1'b0; id_aluop = 4'd0;
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] pool [4];
    pool = '{5'd0, 5'd3, 5'd8, 5'd9};
    return pool[$urandom_range(0, 3)];
  endfunction

  task automatic set_rand();
    rst = ($urandom_range(0, 99) < 3);
    flush = ($urandom_range(0, 99) < 10);
    ext_stall = ($urandom_range(0, 99) < 15);
    id_valid = ($urandom_range(0, 9) < 8);
    id_rs = pick_reg(); id_rt = pick_reg(); id_rd = 5'($urandom);
    id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; id_pc4 = $urandom;
    id_regdst = 1'($urandom); id_regwrite = 1'($urandom); id_memread = 1'($urandom);
    id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom); id_alusrc = 1'($urandom);
    id_aluop = 4'($urandom);
  endtask

  // One clock: compare DUT to model mid-cycle, then advance the model across the edge.
  task automatic tick(input bit do_chk);
    rec_t nxt;
    bit haz;
    int sc, fc;
    @(negedge clk);
    haz = model_hazard();
    if (do_chk) begin
      chk("hazard_stall", 160'(hazard_stall), 160'(haz));
      chk("ex_fields", 160'(dut_view()), 160'(m_ex));
      chk("ex_wreg", 160'(ex_wreg), 160'(m_ex.regdst ? m_ex.rd : m_ex.rt));
      chk("stall_count", 160'(stall_count), 160'(m_sc));
      chk("flush_count", 160'(flush_count), 160'(m_fc));
    end
    nxt = m_ex; sc = m_sc; fc = m_fc;
    if (rst) begin
      nxt = '0; sc = 0; fc = 0;
    end else begin
      if (flush) begin
        nxt = '0;
        fc = (fc < int'(MAXC)) ? fc + 1 : fc;
      end else if (ext_stall) begin
        nxt = m_ex;
      end else if (haz) begin
        nxt = '0;
        sc = (sc < int'(MAXC)) ? sc + 1 : sc;
      end else begin
        nxt = id_view();
      end
    end
    @(posedge clk);
    m_ex = nxt; m_sc = sc; m_fc = fc;
    #1;
  endtask

  task automatic do_reset();
    set_rand();
    rst = 1'b1;
    tick(1'b0);
  endtask

  task automatic drive_lw8();
    set_nop();
    id_valid = 1'b1; id_memread = 1'b1; id_regwrite = 1'b1; id_memtoreg = 1'b1;
    id_rt = 5'd8; id_rs = 5'd4; id_uses_rs = 1'b1; id_alusrc = 1'b1;
  endtask

  task automatic drive_add_rs8();
    set_nop();
    id_valid = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1; id_rt = 5'd3; id_uses_rt = 1'b1;
    id_rd = 5'd9; id_regdst = 1'b1; id_regwrite = 1'b1; id_aluop = 4'd2;
  endtask

  logic [CW-1:0] sat_exp [5];

  initial begin
    m_ex = '0; m_sc = 0; m_fc = 0;
    set_nop();

    // Reset with random inputs.
    do_reset();
    set_nop();
    chk("reset_ex_valid", 160'(ex_valid), 160'(1'b0));
    chk("reset_fields", 160'(dut_view()), 160'(0));
    chk("reset_wreg", 160'(ex_wreg), 160'(5'd0));
    chk("reset_counts", 160'({stall_count, flush_count}), 160'(0));
    #1 chk("reset_hazard", 160'(hazard_stall), 160'(1'b0));

    // lw $8 then add $9,$8,$3: one-cycle stall, bubble, then the add enters EX.
    drive_lw8(); tick(1'b1);
    drive_add_rs8();
    #1 chk("lu_hazard", 160'(hazard_stall), 160'(1'b1));
    tick(1'b1);
    chk("lu_bubble_valid", 160'(ex_valid), 160'(1'b0));
    chk("lu_bubble_rs", 160'(ex_rs), 160'(5'd0));
    chk("lu_stall_count", 160'(stall_count), 160'(2'd1));
    #1 chk("lu_hazard_drop", 160'(hazard_stall), 160'(1'b0));
    tick(1'b1);
    chk("lu_add_valid", 160'(ex_valid), 160'(1'b1));
    chk("lu_add_rs", 160'(ex_rs), 160'(5'd8));
    chk("lu_add_wreg", 160'(ex_wreg), 160'(5'd9));

    // $0 loads and non-reading fields never stall.
    do_reset();
    drive_lw8(); id_rt = 5'd0; tick(1'b1);
    set_nop(); id_valid = 1'b1; id_rs = 5'd0; id_uses_rs = 1'b1; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1 chk("r0_no_hazard", 160'(hazard_stall), 160'(1'b0));
    tick(1'b1);
    drive_lw8(); tick(1'b1);
    set_nop(); id_valid = 1'b1; id_rs = 5'd5; id_uses_rs = 1'b1; id_rt = 5'd8; id_uses_rt = 1'b0;
    #1 chk("unused_rt_no_hazard", 160'(hazard_stall), 160'(1'b0));
    tick(1'b1);

    // Flush coincident with a load-use hazard.
    do_reset();
    drive_lw8(); tick(1'b1);
    drive_add_rs8(); flush = 1'b1;
    #1 chk("fl_hazard", 160'(hazard_stall), 160'(1'b1));
    tick(1'b1);
    chk("fl_bubble", 160'(ex_valid), 160'(1'b0));
    chk("fl_counts", 160'({stall_count, flush_count}), 160'({2'd0, 2'd1}));

    // ext_stall holds EX for three cycles while ID changes.
    do_reset();
    set_nop(); id_valid = 1'b1; id_pc4 = 32'hCAFE_0004; id_rd = 5'd7; id_regdst = 1'b1;
    tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      set_rand(); rst = 1'b0; flush = 1'b0; ext_stall = 1'b1;
      tick(1'b1);
      chk("hold_pc4", 160'(ex_pc4), 160'(32'hCAFE_0004));
      chk("hold_wreg", 160'(ex_wreg), 160'(5'd7));
    end
    set_nop(); id_valid = 1'b1; id_pc4 = 32'h0000_1234;
    tick(1'b1);
    chk("resume_pc4", 160'(ex_pc4), 160'(32'h0000_1234));

    // Five load-use stalls saturate the 2-bit counter.
    do_reset();
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      drive_lw8(); tick(1'b1);
      drive_add_rs8(); tick(1'b1);
      chk("sat_stall_count", 160'(stall_count), 160'(sat_exp[i]));
    end

    // Randomized traffic against the model, including mid-stall resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_rand();
      tick(1'b1);
    end
    set_nop();
    tick(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
